// File: rtl/comb2_result_fifo.sv
// Capture stage for comb2 results: packs the nine result outputs into a 24-bit word and
// buffers it in a show-ahead FIFO drained over valid/ready, with Equality and drop statistics.
module comb2_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               Arithmetic,
    input  logic [3:0]               Shift,
    input  logic [3:0]               Bitwise,
    input  logic [3:0]               Concatenation,
    input  logic [3:0]               Conditional,
    input  logic                     Relational,
    input  logic                     Equality,
    input  logic                     Reduction,
    input  logic                     Logical,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [23:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         eq_count,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef logic [23:0] word_t;

    word_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [CNT_W-1:0]   eq_count_q, eq_count_d;
    logic               drop_q, drop_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    word_t              push_word;

    assign push_word = {Arithmetic, Shift, Bitwise, Concatenation, Conditional,
                        Relational, Equality, Reduction, Logical};

    // Flags come from the registered occupancy only, so no input reaches an output combinationally.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    assign push = in_valid && !full;
    assign pop  = !empty && out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        eq_count_d = eq_count_q;
        drop_d     = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push && Equality && (eq_count_q != '1)) begin
            eq_count_d = eq_count_q + 1'b1;
        end

        if (in_valid && full) begin
            drop_d = 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            eq_count_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            eq_count_q <= eq_count_d;
            drop_q     <= drop_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign eq_count  = eq_count_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_comb2_result_fifo.sv
// Directed bench for comb2_result_fifo: a vector table for reset/fill/stall/drain, then
// hand-written sequences for wrap, empty push, full pop, mid-stream reset and saturation.
module tb_comb2_result_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [23:0] in_word;

    logic [3:0] arith_w, shift_w, bitw_w, concat_w, cond_w;
    logic       rel_w, eq_w, red_w, log_w;

    assign arith_w  = in_word[23:20];
    assign shift_w  = in_word[19:16];
    assign bitw_w   = in_word[15:12];
    assign concat_w = in_word[11:8];
    assign cond_w   = in_word[7:4];
    assign rel_w    = in_word[3];
    assign eq_w     = in_word[2];
    assign red_w    = in_word[1];
    assign log_w    = in_word[0];

    logic        in_ready, out_valid, drop;
    logic [23:0] out_data;
    logic [2:0]  count;
    logic [7:0]  eq_count;

    logic        s_in_ready, s_out_valid, s_drop;
    logic [23:0] s_out_data;
    logic [2:0]  s_count;
    logic [1:0]  s_eq_count;

    comb2_result_fifo #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Arithmetic(arith_w), .Shift(shift_w), .Bitwise(bitw_w),
        .Concatenation(concat_w), .Conditional(cond_w),
        .Relational(rel_w), .Equality(eq_w), .Reduction(red_w), .Logical(log_w),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .eq_count(eq_count), .drop(drop)
    );

    // Same stimulus, narrow statistics counter to exercise saturation.
    comb2_result_fifo #(.DEPTH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .Arithmetic(arith_w), .Shift(shift_w), .Bitwise(bitw_w),
        .Concatenation(concat_w), .Conditional(cond_w),
        .Relational(rel_w), .Equality(eq_w), .Reduction(red_w), .Logical(log_w),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .count(s_count), .eq_count(s_eq_count), .drop(s_drop)
    );

    typedef struct {
        logic        rst;
        logic        in_valid;
        logic        out_ready;
        logic [23:0] in_word;
        logic        exp_valid;
        logic        exp_in_ready;
        logic [2:0]  exp_count;
        logic [23:0] exp_data;
        logic [7:0]  exp_eq;
        logic        exp_drop;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step(input logic r, input logic iv, input logic ordy, input logic [23:0] w);
        rst       = r;
        in_valid  = iv;
        out_ready = ordy;
        in_word   = w;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic r, input logic iv, input logic ordy,
                                input logic [23:0] w, input logic ev, input logic eir,
                                input logic [2:0] ec, input logic [23:0] ed,
                                input logic [7:0] eeq, input logic edr);
        vec_t v;
        v.rst = r; v.in_valid = iv; v.out_ready = ordy; v.in_word = w;
        v.exp_valid = ev; v.exp_in_ready = eir; v.exp_count = ec;
        v.exp_data = ed; v.exp_eq = eeq; v.exp_drop = edr;
        return v;
    endfunction

    localparam int N_VEC = 13;
    vec_t vecs [N_VEC];

    logic [23:0] sb [$];
    logic [23:0] w;

    initial begin
        // Fields 2,3,4,5,6 / Rel=1 Eq=0 Red=1 Log=1 pack to 24'h23456B.
        // W0..W3 and the dropped fifth word all have Equality (bit 2) set.
        vecs[0]  = mk(1, 0, 0, 24'h0,      0, 1, 3'd0, 24'h0,      8'd0, 0);
        vecs[1]  = mk(1, 0, 0, 24'h0,      0, 1, 3'd0, 24'h0,      8'd0, 0);
        vecs[2]  = mk(0, 1, 0, 24'h23456B, 1, 1, 3'd1, 24'h23456B, 8'd0, 0);
        vecs[3]  = mk(0, 0, 1, 24'h0,      0, 1, 3'd0, 24'h0,      8'd0, 0);
        vecs[4]  = mk(0, 1, 0, 24'h111114, 1, 1, 3'd1, 24'h111114, 8'd1, 0);
        vecs[5]  = mk(0, 1, 0, 24'h22222C, 1, 1, 3'd2, 24'h111114, 8'd2, 0);
        vecs[6]  = mk(0, 1, 0, 24'h333335, 1, 1, 3'd3, 24'h111114, 8'd3, 0);
        vecs[7]  = mk(0, 1, 0, 24'h44444F, 1, 0, 3'd4, 24'h111114, 8'd4, 0);
        vecs[8]  = mk(0, 1, 0, 24'hABCDE4, 1, 0, 3'd4, 24'h111114, 8'd4, 1);
        vecs[9]  = mk(0, 0, 1, 24'h0,      1, 1, 3'd3, 24'h22222C, 8'd4, 1);
        vecs[10] = mk(0, 0, 1, 24'h0,      1, 1, 3'd2, 24'h333335, 8'd4, 1);
        vecs[11] = mk(0, 0, 1, 24'h0,      1, 1, 3'd1, 24'h44444F, 8'd4, 1);
        vecs[12] = mk(0, 0, 1, 24'h0,      0, 1, 3'd0, 24'h0,      8'd4, 1);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_word = '0;
        @(negedge clk);

        for (int i = 0; i < N_VEC; i++) begin
            step(vecs[i].rst, vecs[i].in_valid, vecs[i].out_ready, vecs[i].in_word);
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].exp_in_ready));
            check($sformatf("v%0d count", i),     32'(count),     32'(vecs[i].exp_count));
            check($sformatf("v%0d eq_count", i),  32'(eq_count),  32'(vecs[i].exp_eq));
            check($sformatf("v%0d drop", i),      32'(drop),      32'(vecs[i].exp_drop));
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
            end
        end
        check("sat eq_count after fill", 32'(s_eq_count), 32'd3);

        // Push into an empty FIFO with out_ready high: no pop, word visible next cycle.
        step(0, 1, 1, 24'h0F0F00);
        sb.push_back(24'h0F0F00);
        check("empty push count", 32'(count), 32'd1);
        check("empty push out_valid", 32'(out_valid), 32'd1);
        check("empty push out_data", 32'(out_data), 32'(sb[0]));

        step(0, 1, 0, 24'h123450);
        sb.push_back(24'h123450);
        check("prefill count", 32'(count), 32'd2);

        // Ten cycles of simultaneous push and pop; pointers wrap several times.
        for (int i = 0; i < 10; i++) begin
            w = {4'h6, 4'(i), 12'hA50, 4'h0};
            step(0, 1, 1, w);
            sb.push_back(w);
            void'(sb.pop_front());
            check($sformatf("wrap%0d count", i), 32'(count), 32'd2);
            check($sformatf("wrap%0d out_data", i), 32'(out_data), 32'(sb[0]));
        end
        check("wrap eq_count", 32'(eq_count), 32'd4);

        // Full with a pop offered alongside a push: no push, ready returns afterwards.
        step(0, 1, 0, 24'h700010);
        sb.push_back(24'h700010);
        step(0, 1, 0, 24'h700020);
        sb.push_back(24'h700020);
        check("full count", 32'(count), 32'd4);
        check("full in_ready", 32'(in_ready), 32'd0);
        step(0, 1, 1, 24'h700030);
        void'(sb.pop_front());
        check("full pop count", 32'(count), 32'd3);
        check("full pop in_ready", 32'(in_ready), 32'd1);
        check("full pop out_data", 32'(out_data), 32'(sb[0]));

        // Reset with count=3 and push/pop both active.
        step(1, 1, 1, 24'h000004);
        check("midrst count", 32'(count), 32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst drop", 32'(drop), 32'd0);
        check("midrst eq_count", 32'(eq_count), 32'd0);
        check("midrst sat eq_count", 32'(s_eq_count), 32'd0);

        // Five Equality=1 pushes drained as they arrive.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, {4'h9, 4'(i), 12'h000, 4'h4});
        end
        check("sat count", 32'(count), 32'd1);
        check("sat out_data", 32'(out_data), 32'h940004);
        check("sat eq_count wide", 32'(eq_count), 32'd5);
        check("sat eq_count narrow", 32'(s_eq_count), 32'd3);
        check("sat drop", 32'(drop), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/comb2_result_fifo.md
# comb2_result_fifo

Downstream capture stage for the `comb2` operator block. It samples the nine `comb2` result outputs when the producer asserts `in_valid` and packs them into one 24-bit word. Words are held in a small synchronous FIFO and drained over a valid/ready interface, so results are no longer lost when the consumer stalls. It also keeps a saturating count of accepted words with `Equality` set, and a sticky flag for words offered while the FIFO was full.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `CNT_W`, default 8: width of `eq_count`.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: a `comb2` result is offered this cycle.
- `in_ready`  out  1: FIFO can accept; equals `!full`.
- `Arithmetic`, `Shift`, `Bitwise`, `Concatenation`, `Conditional`  in  4 each: `comb2` vector results.
- `Relational`, `Equality`, `Reduction`, `Logical`  in  1 each: `comb2` scalar results.
- `out_valid`  out  1: head entry present; equals `!empty`.
- `out_ready`  in  1: consumer accepts the head this cycle.
- `out_data`  out  24: head word, packed as {Arithmetic[23:20], Shift[19:16], Bitwise[15:12], Concatenation[11:8], Conditional[7:4], Relational[3], Equality[2], Reduction[1], Logical[0]}.
- `count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `eq_count`  out  CNT_W: accepted words with Equality=1; saturates at 2^CNT_W−1.
- `drop`  out  1: sticky; set when `in_valid` is high and `in_ready` is low.

## Operation
- Storage is a register array of DEPTH×24 bits, with read and write pointers of $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH.
  - Full and empty are derived from `count`.
- Push: `in_valid && in_ready`. The packed word is written at `wr_ptr`, then `wr_ptr` increments.
- Pop: `out_valid && out_ready`. `rd_ptr` increments; the entry is not cleared.
- `out_data` is a combinational read of `mem[rd_ptr]` (show-ahead). Its value is don't-care while `out_valid=0`; the bench must not check it then.
- Occupancy per cycle:
  - push only: `count` +1.
  - pop only: `count` −1.
  - push and pop together: `count` unchanged, both pointers advance.
- Full: `in_ready=0` and no push happens, even if a pop occurs the same cycle. There is no full-bypass, so `in_ready` rises the cycle after the pop.
- Empty: `out_valid=0`. A push and a simultaneous `out_ready` perform no pop; the word becomes visible the next cycle.
- `eq_count` increments on each push whose Equality input is 1. It holds at all-ones.
- `drop` is set on any cycle with `in_valid=1 && in_ready=0`. Only `rst` clears it.
- There is no state machine beyond the occupancy counter. Legal `count` values are 0..DEPTH.

## Timing
- Reset values, one cycle after `rst` is sampled high:
  - `wr_ptr=0`, `rd_ptr=0`, `count=0`.
  - `out_valid=0`, `in_ready=1`.
  - `eq_count=0`, `drop=0`.
  - Array contents are not reset.
- Reset asserted mid-operation discards all stored words, including on a cycle with push or pop active. `rst` has priority over every other update.
- Latency from push to `out_valid`: 1 cycle when the FIFO was empty.
- Sustained throughput: one push and one pop per cycle whenever 0 < `count` < DEPTH.
- `in_ready`, `out_valid` and `count` are functions of registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Handshake rules:
  - The producer may drop `in_valid` at any time.
  - `out_data` is stable while `out_valid=1` and `out_ready=0`.

## Test plan
- Reset then single push:
  - Stimulus: `rst` for 2 cycles, then push Arith=0x2, Shift=0x3, Bit=0x4, Concat=0x5, Cond=0x6, Rel=1, Eq=0, Red=1, Log=1.
  - Response: next cycle `out_valid=1`, `out_data=24'h23456B`, `count=1`, `eq_count=0`.
- Fill and stall:
  - Stimulus: 4 pushes with Equality=1 (DEPTH=4) and `out_ready=0`, then a 5th offered.
  - Response: `count=4`, `in_ready=0`, `eq_count=4`, `drop=1`. The 5th word never appears.
- Drain order:
  - Stimulus: from full with words W0..W3, hold `out_ready=1` for 4 cycles.
  - Response: `out_data` presents W0, W1, W2, W3 in order, then `out_valid=0`, `count=0`. `drop` stays 1.
- Simultaneous push/pop with wrap:
  - Stimulus: `count=2`, then 10 cycles of `in_valid=1`, `out_ready=1`.
  - Response: `count` stays 2, pointers wrap past 3→0, and output order matches input order.
- Empty push + ready:
  - Stimulus: `count=0`, push with `out_ready=1`.
  - Response: no pop; next cycle `count=1` and `out_valid=1`.
- Reset mid-stream and saturation:
  - Stimulus: `rst` while `count=3`.
  - Response: next cycle `count=0`, `out_valid=0`, `drop=0`.
  - Stimulus: with CNT_W=2, make 5 Equality=1 pushes.
  - Response: `eq_count=3`.
